// File: rtl/divekick_key_decoder.sv
// Keyboard front end for Divekick: debounces the packed HID keycode word, decodes the
// five game buttons and samples them once per frame into level/press/release/hold outputs.
module divekick_key_decoder #(
  parameter logic [7:0]  P1_DIVE_KEY   = 8'h04,
  parameter logic [7:0]  P1_KICK_KEY   = 8'h16,
  parameter logic [7:0]  P2_DIVE_KEY   = 8'h0E,
  parameter logic [7:0]  P2_KICK_KEY   = 8'h0F,
  parameter logic [7:0]  START_KEY     = 8'h2C,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic [31:0] keycode_in,
  input  logic        frame_tick,
  output logic [4:0]  btn_level,
  output logic [4:0]  btn_press,
  output logic [4:0]  btn_release,
  output logic [39:0] hold_frames,
  output logic        rollover_err
);

  localparam logic [7:0]  LP_STABLE    = 8'(STABLE_CYCLES);
  localparam logic [7:0]  LP_STABLE_M1 = 8'(STABLE_CYCLES - 1);
  localparam logic [7:0]  LP_ROLLOVER  = 8'h01;
  localparam logic [39:0] LP_KEYS      = {START_KEY, P2_KICK_KEY, P2_DIVE_KEY,
                                          P1_KICK_KEY, P1_DIVE_KEY};

  // A zero code means the button is unmapped, so it never matches an empty slot.
  function automatic logic key_hit(input logic [31:0] word, input logic [7:0] code);
    logic hit;
    hit = 1'b0;
    for (int b = 0; b < 4; b++) begin
      if (word[8*b +: 8] == code) hit = 1'b1;
    end
    return hit && (code != 8'h00);
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [31:0] r_cap_p0;
  logic [7:0]  r_cnt_p0;
  logic        w_match_p0;
  logic [31:0] r_filt_p1;
  logic [4:0]  w_raw_p1;
  logic        w_err_p1;
  logic [4:0]  r_level_p2;
  logic [4:0]  r_press_p2;
  logic [4:0]  r_release_p2;
  logic [39:0] r_hold_p2;
  logic        r_err_p2;

  // Stage p0/p1: stability filter
  assign w_match_p0 = (keycode_in == r_cap_p0);

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_cap_p0  <= '0;
      r_cnt_p0  <= '0;
      r_filt_p1 <= '0;
    end else begin
      r_cap_p0 <= keycode_in;
      if (w_match_p0) begin
        r_cnt_p0 <= (r_cnt_p0 >= LP_STABLE) ? LP_STABLE : r_cnt_p0 + 8'd1;
        if (r_cnt_p0 >= LP_STABLE_M1) r_filt_p1 <= r_cap_p0;
      end else begin
        r_cnt_p0 <= '0;
      end
    end
  end

  // Stage p1: combinational button decode from the filtered word
  always_comb begin
    w_raw_p1 = '0;
    for (int i = 0; i < 5; i++) begin
      w_raw_p1[i] = key_hit(r_filt_p1, LP_KEYS[8*i +: 8]);
    end
    w_err_p1 = key_hit(r_filt_p1, LP_ROLLOVER);
  end

  // Stage p2: per-frame sample; a rollover frame freezes level and hold counts
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_level_p2   <= '0;
      r_press_p2   <= '0;
      r_release_p2 <= '0;
      r_hold_p2    <= '0;
      r_err_p2     <= 1'b0;
    end else begin
      r_press_p2   <= '0;
      r_release_p2 <= '0;
      if (frame_tick) begin
        if (!w_err_p1) begin
          r_level_p2   <= w_raw_p1;
          r_press_p2   <= w_raw_p1 & ~r_level_p2;
          r_release_p2 <= ~w_raw_p1 & r_level_p2;
          r_err_p2     <= 1'b0;
          for (int i = 0; i < 5; i++) begin
            r_hold_p2[8*i +: 8] <= w_raw_p1[i] ? sat_inc(r_hold_p2[8*i +: 8]) : 8'd0;
          end
        end else begin
          r_err_p2 <= 1'b1;
        end
      end
    end
  end

  assign btn_level    = r_level_p2;
  assign btn_press    = r_press_p2;
  assign btn_release  = r_release_p2;
  assign hold_frames  = r_hold_p2;
  assign rollover_err = r_err_p2;

endmodule

// File: tb/tb_divekick_key_decoder.sv
// Scoreboard bench for divekick_key_decoder: stimulus queues the expected frame sample,
// a monitor compares it on the cycle after each frame_tick.
module tb_divekick_key_decoder;

  typedef struct packed {
    logic [4:0]  lvl;
    logic [4:0]  prs;
    logic [4:0]  rls;
    logic [39:0] hold;
    logic        err;
  } exp_t;

  logic        clk_clk = 1'b0;
  logic        reset_reset = 1'b1;
  logic [31:0] keycode_in = '0;
  logic        frame_tick = 1'b0;
  logic [4:0]  btn_level;
  logic [4:0]  btn_press;
  logic [4:0]  btn_release;
  logic [39:0] hold_frames;
  logic        rollover_err;

  int   n_pass = 0;
  int   n_total = 0;
  exp_t exp_q[$];

  divekick_key_decoder dut (
    .clk_clk      (clk_clk),
    .reset_reset  (reset_reset),
    .keycode_in   (keycode_in),
    .frame_tick   (frame_tick),
    .btn_level    (btn_level),
    .btn_press    (btn_press),
    .btn_release  (btn_release),
    .hold_frames  (hold_frames),
    .rollover_err (rollover_err)
  );

  always #5 clk_clk = ~clk_clk;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic exp_t mk(input logic [4:0] lvl, input logic [4:0] prs,
                              input logic [4:0] rls, input logic [39:0] hold,
                              input logic err);
    exp_t e;
    e.lvl = lvl; e.prs = prs; e.rls = rls; e.hold = hold; e.err = err;
    return e;
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk_clk);
    #1;
  endtask

  // Called just after a rising edge; frame_tick is sampled on the next edge.
  task automatic tick_pulse(input exp_t e);
    exp_q.push_back(e);
    frame_tick = 1'b1;
    @(posedge clk_clk);
    #1 frame_tick = 1'b0;
    @(posedge clk_clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_level"},   {35'b0, btn_level},    40'b0);
    check({tag, "_press"},   {35'b0, btn_press},    40'b0);
    check({tag, "_release"}, {35'b0, btn_release},  40'b0);
    check({tag, "_hold"},    hold_frames,           40'b0);
    check({tag, "_rollerr"}, {39'b0, rollover_err}, 40'b0);
  endtask

  // Monitor: outputs of a frame sample are visible the cycle after the tick edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_clk);
      if (frame_tick && !reset_reset) begin
        @(negedge clk_clk);
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_sample: frame output with empty queue, required none");
        end else begin
          e = exp_q.pop_front();
          check("level",   {35'b0, btn_level},    {35'b0, e.lvl});
          check("press",   {35'b0, btn_press},    {35'b0, e.prs});
          check("release", {35'b0, btn_release},  {35'b0, e.rls});
          check("hold",    hold_frames,           e.hold);
          check("rollerr", {39'b0, rollover_err}, {39'b0, e.err});
        end
        @(negedge clk_clk);
        check("pulse_clear", {30'b0, btn_press, btn_release}, 40'b0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    wait_cycles(3);
    reset_reset = 1'b0;
    check_all_zero("reset");

    // Single press of P1 dive
    keycode_in = 32'h0000_0004;
    wait_cycles(5);
    tick_pulse(mk(5'b00001, 5'b00001, 5'b0, 40'h00_0000_0001, 1'b0));

    // Long hold saturates at 255, then release
    for (int n = 2; n <= 300; n++) begin
      tick_pulse(mk(5'b00001, 5'b0, 5'b0, {32'b0, (n < 255) ? 8'(n) : 8'hFF}, 1'b0));
    end
    keycode_in = 32'h0;
    wait_cycles(5);
    tick_pulse(mk(5'b0, 5'b0, 5'b00001, 40'h0, 1'b0));

    // Glitch held for 3 cycles never reaches the filtered word
    keycode_in = 32'h0F0E_1604;
    wait_cycles(3);
    keycode_in = 32'h0;
    wait_cycles(1);
    tick_pulse(mk(5'b0, 5'b0, 5'b0, 40'h0, 1'b0));
    wait_cycles(5);
    tick_pulse(mk(5'b0, 5'b0, 5'b0, 40'h0, 1'b0));

    // Simultaneous presses, then a rollover frame freezes state
    keycode_in = 32'h2C0F_1604;
    wait_cycles(5);
    tick_pulse(mk(5'b11011, 5'b11011, 5'b0, 40'h01_0100_0101, 1'b0));
    keycode_in = 32'h0101_0101;
    wait_cycles(5);
    tick_pulse(mk(5'b11011, 5'b0, 5'b0, 40'h01_0100_0101, 1'b1));
    keycode_in = 32'h2C0F_1604;
    wait_cycles(5);
    tick_pulse(mk(5'b11011, 5'b0, 5'b0, 40'h02_0200_0202, 1'b0));
    keycode_in = 32'h0;
    wait_cycles(5);
    tick_pulse(mk(5'b0, 5'b0, 5'b11011, 40'h0, 1'b0));

    // Filter boundary: change right after edge k, tick at k+4, k+5, k+6
    keycode_in = 32'h0000_0004;
    wait_cycles(5);
    tick_pulse(mk(5'b00001, 5'b00001, 5'b0, 40'h01, 1'b0));
    keycode_in = 32'h0000_0016;
    wait_cycles(3);
    tick_pulse(mk(5'b00001, 5'b0, 5'b0, 40'h02, 1'b0));
    keycode_in = 32'h0000_0004;
    wait_cycles(5);
    tick_pulse(mk(5'b00001, 5'b0, 5'b0, 40'h03, 1'b0));
    keycode_in = 32'h0000_0016;
    wait_cycles(4);
    tick_pulse(mk(5'b00001, 5'b0, 5'b0, 40'h04, 1'b0));
    keycode_in = 32'h0000_0004;
    wait_cycles(5);
    tick_pulse(mk(5'b00001, 5'b0, 5'b0, 40'h05, 1'b0));
    keycode_in = 32'h0000_0016;
    wait_cycles(5);
    tick_pulse(mk(5'b00010, 5'b00010, 5'b00001, 40'h00_0000_0100, 1'b0));
    keycode_in = 32'h0;
    wait_cycles(5);
    tick_pulse(mk(5'b0, 5'b0, 5'b00010, 40'h0, 1'b0));

    // Reset mid-hold discards state; the held key presses again afterwards
    keycode_in = 32'h0000_0004;
    wait_cycles(5);
    tick_pulse(mk(5'b00001, 5'b00001, 5'b0, 40'h01, 1'b0));
    for (int n = 2; n <= 10; n++) begin
      tick_pulse(mk(5'b00001, 5'b0, 5'b0, {32'b0, 8'(n)}, 1'b0));
    end
    reset_reset = 1'b1;
    wait_cycles(1);
    reset_reset = 1'b0;
    check_all_zero("midreset");
    wait_cycles(5);
    tick_pulse(mk(5'b00001, 5'b00001, 5'b0, 40'h01, 1'b0));

    wait_cycles(3);
    check("queue_drained", 40'(exp_q.size()), 40'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
